fifo_burst_reader: RTL and testbench

- Drain side of the single-clock byte FIFO that buffers JPEG encoder output.
- Pops words from the FIFO, absorbs its 1-cycle registered read latency, and presents a valid/ready stream to the ESP32 host interface in fixed-length bursts, with m_last on the final beat.
- On end-of-frame (flush), completes the current burst with a pad value so the host always receives whole bursts.

---
 rtl/fifo_burst_reader.sv | 151 +++++++++++++++
 tb/tb_fifo_burst_reader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Drain side of the JPEG output FIFO. It pops words into a 2-entry skid buffer and streams them in fixed-length bursts, padding the burst on flush.
// Optional define FIFO_RD_WATERMARK_EN holds off reads until the FIFO can supply the rest of the burst.

module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 10,
    parameter int LEN_WIDTH  = 10,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    input  logic [CNT_WIDTH-1:0]  fifo_cnt,
    output logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RUN, PAD, DONE} state_t;

    state_t                r_state;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_delivered;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [1:0]            r_occ;
    logic                  r_inflight;

    logic       w_hsk;
    logic       w_popBuf;
    logic [2:0] w_level;
    logic       w_rdGate;
    logic       w_padStart;

`ifdef FIFO_RD_WATERMARK_EN
    localparam int CMP_WIDTH = (CNT_WIDTH > LEN_WIDTH) ? CNT_WIDTH : LEN_WIDTH;

    logic                 r_gateOpen;
    logic [CMP_WIDTH-1:0] w_cntExt;
    logic [CMP_WIDTH-1:0] w_remain;

    // Once the FIFO holds the whole remainder of the burst the gate latches open.
    assign w_cntExt = CMP_WIDTH'(fifo_cnt);
    assign w_remain = CMP_WIDTH'(r_len - r_issued);
    assign w_rdGate = r_gateOpen || flush || (w_cntExt >= w_remain);
`else
    logic w_unusedCnt;

    assign w_unusedCnt = ^fifo_cnt;
    assign w_rdGate    = 1'b1;
`endif

    assign w_hsk      = m_valid && m_ready;
    assign w_popBuf   = w_hsk && (r_occ != 2'd0);
    assign w_level    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_popBuf};
    assign w_padStart = flush && fifo_empty && !r_inflight && (r_issued < r_len);

    // Reads are suppressed during reset so no word is popped only to be thrown away.
    assign fifo_read = !reset && (r_state == RUN) && !fifo_empty && (r_issued < r_len)
                       && (w_level < 3'd2) && w_rdGate;

    assign m_valid = (r_occ != 2'd0) || (r_state == PAD);
    assign m_data  = ((r_state == PAD) && (r_occ == 2'd0)) ? PAD_VALUE : r_buf0;
    assign m_last  = m_valid && (r_delivered == r_len - 1'b1);
    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_buf0      <= '0;
            r_buf1      <= '0;
            r_occ       <= 2'd0;
            r_inflight  <= 1'b0;
`ifdef FIFO_RD_WATERMARK_EN
            r_gateOpen  <= 1'b0;
`endif
        end else begin
            r_inflight <= fifo_read;
            if (fifo_read) r_issued <= r_issued + 1'b1;
            if (w_hsk) r_delivered <= r_delivered + 1'b1;

            // The word popped last cycle lands behind whatever the host has not yet taken.
            case (r_occ)
                2'd0: begin
                    if (r_inflight) begin
                        r_buf0 <= fifo_data;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_popBuf && r_inflight) begin
                        r_buf0 <= fifo_data;
                    end else if (w_popBuf) begin
                        r_occ <= 2'd0;
                    end else if (r_inflight) begin
                        r_buf1 <= fifo_data;
                        r_occ  <= 2'd2;
                    end
                end
                2'd2: begin
                    if (w_popBuf) begin
                        r_buf0 <= r_buf1;
                        if (r_inflight) r_buf1 <= fifo_data;
                        else            r_occ  <= 2'd1;
                    end
                end
                default: r_occ <= 2'd0;
            endcase

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len       <= burst_len;
                        r_issued    <= '0;
                        r_delivered <= '0;
`ifdef FIFO_RD_WATERMARK_EN
                        r_gateOpen  <= 1'b0;
`endif
                        r_state     <= (burst_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
`ifdef FIFO_RD_WATERMARK_EN
                    if (w_rdGate) r_gateOpen <= 1'b1;
`endif
                    if (w_hsk && m_last)  r_state <= DONE;
                    else if (w_padStart)  r_state <= PAD;
                end
                PAD: begin
                    if (w_hsk && m_last) r_state <= DONE;
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural 1-cycle-latency FIFO on the read side.
// The watermark scenario runs only when FIFO_RD_WATERMARK_EN is defined.

module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int CW = 10;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          flush;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_read;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          done;

    int passCount  = 0;
    int checkCount = 0;
    int emptyViol  = 0;

    logic [7:0] mem [0:255];
    int wrPtr = 0;
    int rdPtr = 0;

    fifo_burst_reader #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW),
        .LEN_WIDTH (LW),
        .PAD_VALUE (8'hFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .burst_len (burst_len),
        .flush     (flush),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_cnt  (fifo_cnt),
        .fifo_read (fifo_read),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wrPtr == rdPtr);
    assign fifo_cnt   = CW'(wrPtr - rdPtr);

    // Registered read port: a pop in cycle N shows its word in cycle N+1.
    always @(posedge clk) begin
        if (fifo_read && fifo_empty) emptyViol <= emptyViol + 1;
        if (fifo_read && !fifo_empty) begin
            fifo_data <= mem[rdPtr[7:0]];
            rdPtr     <= rdPtr + 1;
        end
    end

    task automatic pushByte(input logic [7:0] b);
        mem[wrPtr[7:0]] = b;
        wrPtr = wrPtr + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0; m_ready = 1'b0; burst_len = '0;
        repeat (2) @(negedge clk);
        #1;
        checkCount++; if (fifo_read !== 1'b0) $display("[TB] FAIL reset_fifo_read: got %b expected 0", fifo_read); else passCount++;
        checkCount++; if (m_valid !== 1'b0) $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); else passCount++;
        checkCount++; if (m_last !== 1'b0) $display("[TB] FAIL reset_m_last: got %b expected 0", m_last); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passCount++;
        checkCount++; if (m_data !== 8'h00) $display("[TB] FAIL reset_m_data: got %h expected 00", m_data); else passCount++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_full_burst();
        logic [15:0] readMask, validMask, lastMask, doneMask, busyMask;
        logic [7:0]  beats [16];
        int          nBeats;
        readMask = '0; validMask = '0; lastMask = '0; doneMask = '0; busyMask = '0; nBeats = 0;
        for (int i = 0; i < 8; i++) pushByte(8'(8'h10 + i));
        @(negedge clk);
        start = 1'b1; burst_len = 10'd8; m_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            readMask[c]  = fifo_read;
            validMask[c] = m_valid;
            lastMask[c]  = m_last;
            doneMask[c]  = done;
            busyMask[c]  = busy;
            if (m_valid && m_ready) begin
                if (nBeats < 16) beats[nBeats] = m_data;
                nBeats++;
            end
            @(negedge clk);
            start = 1'b0;
        end
        checkCount++; if (readMask !== 16'h01FE) $display("[TB] FAIL full_read_cycles: got %h expected 01fe", readMask); else passCount++;
        checkCount++; if (validMask !== 16'h07F8) $display("[TB] FAIL full_valid_cycles: got %h expected 07f8", validMask); else passCount++;
        checkCount++; if (lastMask !== 16'h0400) $display("[TB] FAIL full_last_cycle: got %h expected 0400", lastMask); else passCount++;
        checkCount++; if (doneMask !== 16'h0800) $display("[TB] FAIL full_done_cycle: got %h expected 0800", doneMask); else passCount++;
        checkCount++; if (busyMask !== 16'h0FFE) $display("[TB] FAIL full_busy_cycles: got %h expected 0ffe", busyMask); else passCount++;
        checkCount++; if (nBeats != 8) $display("[TB] FAIL full_beat_count: got %0d expected 8", nBeats); else passCount++;
        for (int i = 0; i < 8; i++) begin
            checkCount++;
            if (beats[i] !== 8'(8'h10 + i)) $display("[TB] FAIL full_beat%0d: got %h expected %h", i, beats[i], 8'(8'h10 + i));
            else passCount++;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] beats [16];
        logic [7:0] prevData;
        logic       prevStall, doneSeen;
        int         nBeats, stallErr;
        nBeats = 0; stallErr = 0; prevStall = 1'b0; prevData = '0; doneSeen = 1'b0;
        for (int i = 0; i < 8; i++) pushByte(8'(8'h10 + i));
        @(negedge clk);
        start = 1'b1; burst_len = 10'd8; m_ready = 1'b1;
        for (int c = 0; c < 60 && !doneSeen; c++) begin
            #1;
            if (prevStall && (!m_valid || m_data !== prevData)) stallErr++;
            if (m_valid && m_ready) begin
                if (nBeats < 16) beats[nBeats] = m_data;
                nBeats++;
            end
            if (done) doneSeen = 1'b1;
            prevStall = m_valid && !m_ready;
            prevData  = m_data;
            @(negedge clk);
            start   = 1'b0;
            m_ready = ~m_ready;
        end
        m_ready = 1'b1;
        checkCount++; if (nBeats != 8) $display("[TB] FAIL bp_beat_count: got %0d expected 8", nBeats); else passCount++;
        for (int i = 0; i < 8; i++) begin
            checkCount++;
            if (beats[i] !== 8'(8'h10 + i)) $display("[TB] FAIL bp_beat%0d: got %h expected %h", i, beats[i], 8'(8'h10 + i));
            else passCount++;
        end
        checkCount++; if (stallErr != 0) $display("[TB] FAIL bp_stall_hold: got %0d unstable stalls expected 0", stallErr); else passCount++;
        checkCount++; if (doneSeen !== 1'b1) $display("[TB] FAIL bp_done: got %b expected 1", doneSeen); else passCount++;
        checkCount++; if (emptyViol != 0) $display("[TB] FAIL bp_read_while_empty: got %0d expected 0", emptyViol); else passCount++;
    endtask

    task automatic test_flush_pad();
        logic [7:0] expBeats [6];
        logic [7:0] beats [16];
        logic [5:0] lastBits;
        logic       doneSeen;
        int         nBeats;
        expBeats = '{8'h30, 8'h31, 8'h32, 8'hFF, 8'hFF, 8'hFF};
        nBeats = 0; lastBits = '0; doneSeen = 1'b0;
        pushByte(8'h30); pushByte(8'h31); pushByte(8'h32);
        @(negedge clk);
        start = 1'b1; burst_len = 10'd6; m_ready = 1'b1;
        for (int c = 0; c < 30 && !doneSeen; c++) begin
            #1;
            if (m_valid && m_ready) begin
                if (nBeats < 6) lastBits[nBeats] = m_last;
                if (nBeats < 16) beats[nBeats] = m_data;
                nBeats++;
            end
            if (done) doneSeen = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (c + 1 >= 4) flush = 1'b1;
        end
        flush = 1'b0;
        checkCount++; if (nBeats != 6) $display("[TB] FAIL pad_beat_count: got %0d expected 6", nBeats); else passCount++;
        for (int i = 0; i < 6; i++) begin
            checkCount++;
            if (beats[i] !== expBeats[i]) $display("[TB] FAIL pad_beat%0d: got %h expected %h", i, beats[i], expBeats[i]);
            else passCount++;
        end
        checkCount++; if (lastBits !== 6'b100000) $display("[TB] FAIL pad_last_position: got %b expected 100000", lastBits); else passCount++;
        checkCount++; if (doneSeen !== 1'b1) $display("[TB] FAIL pad_done: got %b expected 1", doneSeen); else passCount++;
    endtask

    task automatic test_zero_len();
        logic [5:0] busyMask, doneMask;
        logic       readSeen, validSeen;
        busyMask = '0; doneMask = '0; readSeen = 1'b0; validSeen = 1'b0;
        @(negedge clk);
        start = 1'b1; burst_len = 10'd0; m_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            readSeen    = readSeen | fifo_read;
            validSeen   = validSeen | m_valid;
            busyMask[c] = busy;
            doneMask[c] = done;
            @(negedge clk);
            start = 1'b0;
        end
        checkCount++; if (readSeen !== 1'b0) $display("[TB] FAIL zero_fifo_read: got %b expected 0", readSeen); else passCount++;
        checkCount++; if (validSeen !== 1'b0) $display("[TB] FAIL zero_m_valid: got %b expected 0", validSeen); else passCount++;
        checkCount++; if (busyMask !== 6'b000010) $display("[TB] FAIL zero_busy: got %b expected 000010", busyMask); else passCount++;
        checkCount++; if (doneMask !== 6'b000010) $display("[TB] FAIL zero_done: got %b expected 000010", doneMask); else passCount++;
    endtask

`ifdef FIFO_RD_WATERMARK_EN
    task automatic test_watermark();
        logic [7:0] beats [16];
        logic       doneSeen;
        int         firstRead, nBeats;
        firstRead = -1; nBeats = 0; doneSeen = 1'b0;
        @(negedge clk);
        start = 1'b1; burst_len = 10'd4; m_ready = 1'b1;
        for (int c = 0; c < 24 && !doneSeen; c++) begin
            if (c >= 1 && c <= 4) pushByte(8'(8'h5F + c));
            #1;
            if (fifo_read && firstRead < 0) firstRead = c;
            if (m_valid && m_ready) begin
                if (nBeats < 16) beats[nBeats] = m_data;
                nBeats++;
            end
            if (done) doneSeen = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        checkCount++; if (firstRead != 4) $display("[TB] FAIL wm_first_read_cycle: got %0d expected 4", firstRead); else passCount++;
        checkCount++; if (nBeats != 4) $display("[TB] FAIL wm_beat_count: got %0d expected 4", nBeats); else passCount++;
        for (int i = 0; i < 4; i++) begin
            checkCount++;
            if (beats[i] !== 8'(8'h60 + i)) $display("[TB] FAIL wm_beat%0d: got %h expected %h", i, beats[i], 8'(8'h60 + i));
            else passCount++;
        end
        checkCount++; if (doneSeen !== 1'b1) $display("[TB] FAIL wm_done: got %b expected 1", doneSeen); else passCount++;
    endtask
`endif

    task automatic test_reset_abort();
        logic [7:0] beats [16];
        logic       doneSeen;
        int         nBeats;
        nBeats = 0; doneSeen = 1'b0;
        for (int i = 0; i < 8; i++) pushByte(8'(8'h50 + i));
        @(negedge clk);
        start = 1'b1; burst_len = 10'd8; m_ready = 1'b1;
        // Beat 4 (0x53) is on the bus in cycle 6; the reads of 0x50..0x54 have already happened.
        for (int c = 0; c < 8; c++) begin
            if (c == 6) reset = 1'b1;
            if (c == 7) reset = 1'b0;
            #1;
            if (c == 7) begin
                checkCount++; if (m_valid !== 1'b0) $display("[TB] FAIL abort_m_valid: got %b expected 0", m_valid); else passCount++;
                checkCount++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else passCount++;
                checkCount++; if (fifo_read !== 1'b0) $display("[TB] FAIL abort_fifo_read: got %b expected 0", fifo_read); else passCount++;
                checkCount++; if (done !== 1'b0) $display("[TB] FAIL abort_done: got %b expected 0", done); else passCount++;
            end
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b1; burst_len = 10'd2;
        for (int c = 0; c < 20 && !doneSeen; c++) begin
            #1;
            if (m_valid && m_ready) begin
                if (nBeats < 16) beats[nBeats] = m_data;
                nBeats++;
            end
            if (done) doneSeen = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        checkCount++; if (nBeats != 2) $display("[TB] FAIL abort_restart_count: got %0d expected 2", nBeats); else passCount++;
        checkCount++; if (beats[0] !== 8'h55) $display("[TB] FAIL abort_restart_beat0: got %h expected 55", beats[0]); else passCount++;
        checkCount++; if (beats[1] !== 8'h56) $display("[TB] FAIL abort_restart_beat1: got %h expected 56", beats[1]); else passCount++;
        checkCount++; if (doneSeen !== 1'b1) $display("[TB] FAIL abort_restart_done: got %b expected 1", doneSeen); else passCount++;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time %0t reached limit 100000 before the summary", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_full_burst();
        test_backpressure();
        test_flush_pad();
        test_zero_len();
`ifdef FIFO_RD_WATERMARK_EN
        test_watermark();
`endif
        test_reset_abort();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
